// File: rtl/pipeline_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_ctrl
//
// Hazard / stall controller for a classic 5-stage in-order pipeline.
// A small FSM (RUN, MEM_WAIT, FAULT) tracks outstanding data-memory accesses.
// All pipeline control outputs are combinational from the state and the
// current hazard inputs. In RUN, hazards are resolved in priority order:
// memory stall, then taken branch, then load-use.
//
// Ports
//   clk_i            rising-edge clock
//   rst_ni           asynchronous active-low reset
//   ifid_rs1_i/rs2_i source registers of the instruction in IF/ID
//   idex_rd_i        destination register of the instruction in ID/EX
//   idex_memread_i   instruction in ID/EX is a load
//   branch_taken_i   branch/jump resolved taken in EX
//   mem_req_i        data-memory access in MEM
//   mem_ready_i      data-memory completion
//   *_write_o        load enables for PC and pipeline registers
//   ifid_flush_o     load a bubble into IF/ID
//   idex_flush_o     load a bubble into ID/EX
//   memwb_bubble_o   suppress MemtoReg/RegWrite on the MEM/WB load
//   pc_src_o         select the branch target for the PC
//   fault_o          sticky memory-timeout flag
//   stall_cnt_o      saturating count of cycles with pc_write_o == 0
//   flush_cnt_o      saturating count of cycles with ifid_flush_o == 1
// -----------------------------------------------------------------------------
module pipeline_ctrl #(
    parameter int WAIT_MAX = 15,
    parameter int CNT_W    = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [4:0]       ifid_rs1_i,
    input  logic [4:0]       ifid_rs2_i,
    input  logic [4:0]       idex_rd_i,
    input  logic             idex_memread_i,
    input  logic             branch_taken_i,
    input  logic             mem_req_i,
    input  logic             mem_ready_i,
    output logic             pc_write_o,
    output logic             ifid_write_o,
    output logic             idex_write_o,
    output logic             exmem_write_o,
    output logic             memwb_write_o,
    output logic             ifid_flush_o,
    output logic             idex_flush_o,
    output logic             memwb_bubble_o,
    output logic             pc_src_o,
    output logic             fault_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    // Wide enough to hold WAIT_MAX + 1, the value written on the FAULT transition.
    localparam int WAIT_W = $clog2(WAIT_MAX + 1) + 1;
    localparam logic [WAIT_W-1:0] WAIT_MAX_C = WAIT_W'(WAIT_MAX);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        FAULT    = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
    logic              load_use;

    // x0 is hard-wired to zero, so a load targeting it never creates a hazard.
    assign load_use = idex_memread_i && (idex_rd_i != 5'd0) &&
                      ((idex_rd_i == ifid_rs1_i) || (idex_rd_i == ifid_rs2_i));

    always_comb begin
        state_d        = state_q;
        wait_cnt_d     = wait_cnt_q;
        pc_write_o     = 1'b1;
        ifid_write_o   = 1'b1;
        idex_write_o   = 1'b1;
        exmem_write_o  = 1'b1;
        memwb_write_o  = 1'b1;
        ifid_flush_o   = 1'b0;
        idex_flush_o   = 1'b0;
        memwb_bubble_o = 1'b0;
        pc_src_o       = 1'b0;
        fault_o        = 1'b0;

        // While reset is held the outputs stay at the quiet RUN defaults,
        // so hazard inputs cannot produce flushes before the pipeline starts.
        if (rst_ni) begin
            unique case (state_q)
                RUN: begin
                    if (mem_req_i && !mem_ready_i) begin
                        // Freeze everything up to MEM; let a bubble drain into WB.
                        pc_write_o     = 1'b0;
                        ifid_write_o   = 1'b0;
                        idex_write_o   = 1'b0;
                        exmem_write_o  = 1'b0;
                        memwb_bubble_o = 1'b1;
                        state_d        = MEM_WAIT;
                        wait_cnt_d     = WAIT_W'(1);
                    end else if (branch_taken_i) begin
                        // A taken branch squashes the younger instructions,
                        // including one that would otherwise cause a load-use stall.
                        pc_src_o     = 1'b1;
                        ifid_flush_o = 1'b1;
                        idex_flush_o = 1'b1;
                    end else if (load_use) begin
                        // Hold PC and IF/ID for one cycle; the bubble in ID/EX
                        // moves the load forward so the hazard clears next cycle.
                        pc_write_o   = 1'b0;
                        ifid_write_o = 1'b0;
                        idex_flush_o = 1'b1;
                    end
                end

                MEM_WAIT: begin
                    if (mem_ready_i) begin
                        state_d    = RUN;
                        wait_cnt_d = '0;
                    end else begin
                        pc_write_o     = 1'b0;
                        ifid_write_o   = 1'b0;
                        idex_write_o   = 1'b0;
                        exmem_write_o  = 1'b0;
                        memwb_bubble_o = 1'b1;
                        wait_cnt_d     = wait_cnt_q + 1'b1;
                        if (wait_cnt_q == WAIT_MAX_C) begin
                            state_d = FAULT;
                        end
                    end
                end

                FAULT: begin
                    // Terminal until reset; memory completion no longer matters.
                    pc_write_o     = 1'b0;
                    ifid_write_o   = 1'b0;
                    idex_write_o   = 1'b0;
                    exmem_write_o  = 1'b0;
                    memwb_write_o  = 1'b0;
                    memwb_bubble_o = 1'b1;
                    fault_o        = 1'b1;
                end

                default: begin
                    state_d = RUN;
                end
            endcase
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (!pc_write_o && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
        if (ifid_flush_o && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= RUN;
            wait_cnt_q  <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;

endmodule
